// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for the EX-stage branch resolve controller.
// Comparator ops, control-transfer kinds and controller states.
package branch_resolve_ctrl_pkg;

  localparam int CORE_DATA_W = 64;

  typedef logic [CORE_DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    CMP_EQ,
    CMP_NE,
    CMP_LT,
    CMP_GE,
    CMP_LTU,
    CMP_GEU
  } cmp_op_enum;

  typedef enum logic [1:0] {
    CF_BRANCH,
    CF_JAL,
    CF_JALR
  } cf_kind_e;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_RESOLVE,
    BC_RESP,
    BC_FLUSH
  } bc_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_cmp.sv
// Branch comparator: signed/unsigned compare of two operands.
// Purely combinational.
module branch_resolve_ctrl_cmp
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int W = CORE_DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  cmp_op_enum   op,
  output logic         res
);

  always_comb begin
    res = 1'b0;
    unique case (op)
      CMP_EQ:  res = (a == b);
      CMP_NE:  res = (a != b);
      CMP_LT:  res = ($signed(a) < $signed(b));
      CMP_GE:  res = ($signed(a) >= $signed(b));
      CMP_LTU: res = (a < b);
      CMP_GEU: res = (a >= b);
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves branch/JAL/JALR in EX, checks the front-end prediction,
// issues redirect/flush on mispredict and keeps branch statistics.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DATA_W       = CORE_DATA_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  cf_kind_e          req_kind,
  input  cmp_op_enum        req_cmp_op,
  input  logic [DATA_W-1:0] req_pc,
  input  logic [DATA_W-1:0] req_rs1,
  input  logic [DATA_W-1:0] req_rs2,
  input  logic [DATA_W-1:0] req_imm,
  input  logic              req_pred_taken,
  output logic              resp_valid,
  output logic              resp_taken,
  output logic [DATA_W-1:0] link_data,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  output logic              misalign_exc,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  br_total,
  output logic [CNT_W-1:0]  br_mispred
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DATA_W-1:0] INSN_BYTES = DATA_W'(4);

  bc_state_e state_q, state_d;

  cf_kind_e          kind_q;
  cmp_op_enum        op_q;
  logic [DATA_W-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic              pred_q;

  logic              taken_q, mis_q;
  logic [DATA_W-1:0] target_q;
  logic [FW-1:0]     fl_q;

  logic              cmp_res;
  logic              taken_c;
  logic [DATA_W-1:0] target_c;
  logic [DATA_W-1:0] jalr_sum;
  logic [DATA_W-1:0] link_c;
  logic              misal;
  logic              mis_eff;
  logic [1:0]        cnt_inc;

  branch_resolve_ctrl_cmp #(.W(DATA_W)) u_cmp (
    .a   (rs1_q),
    .b   (rs2_q),
    .op  (op_q),
    .res (cmp_res)
  );

  assign jalr_sum = rs1_q + imm_q;
  assign link_c   = pc_q + INSN_BYTES;

  always_comb begin
    taken_c  = 1'b1;
    target_c = pc_q + imm_q;
    unique case (1'b1)
      (kind_q == CF_BRANCH): taken_c = cmp_res;
      (kind_q == CF_JALR):   target_c = {jalr_sum[DATA_W-1:1], 1'b0};
      default: ;
    endcase
  end

  // A misaligned taken target raises an exception instead of a redirect.
  assign misal   = taken_q & target_q[1];
  assign mis_eff = mis_q & ~misal;

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    misalign_exc   = 1'b0;
    unique case (state_q)
      BC_IDLE: begin
        req_ready = rstn;
        if (req_valid) state_d = BC_RESOLVE;
      end
      BC_RESOLVE: state_d = BC_RESP;
      BC_RESP: begin
        resp_valid = 1'b1;
        state_d    = BC_IDLE;
        if (misal) begin
          misalign_exc = 1'b1;
        end else if (mis_q) begin
          redirect_valid = 1'b1;
          flush          = 1'b1;
          if (FLUSH_CYCLES > 1) state_d = BC_FLUSH;
        end
      end
      BC_FLUSH: begin
        flush = 1'b1;
        if (fl_q <= FW'(1)) state_d = BC_IDLE;
      end
      default: state_d = BC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BC_IDLE;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BC_RESP) fl_q <= FW'(FLUSH_CYCLES - 1);
      else if (state_q == BC_FLUSH) fl_q <= fl_q - FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kind_q <= CF_BRANCH;
      op_q   <= CMP_EQ;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      pred_q <= 1'b0;
    end else if (state_q == BC_IDLE && req_valid) begin
      kind_q <= req_kind;
      op_q   <= req_cmp_op;
      pc_q   <= req_pc;
      rs1_q  <= req_rs1;
      rs2_q  <= req_rs2;
      imm_q  <= req_imm;
      pred_q <= req_pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      taken_q     <= 1'b0;
      mis_q       <= 1'b0;
      target_q    <= '0;
      resp_taken  <= 1'b0;
      link_data   <= '0;
      redirect_pc <= '0;
    end else if (state_q == BC_RESOLVE) begin
      taken_q     <= taken_c;
      mis_q       <= taken_c ^ pred_q;
      target_q    <= target_c;
      resp_taken  <= taken_c;
      link_data   <= link_c;
      redirect_pc <= taken_c ? target_c : link_c;
    end
  end

  assign cnt_inc = {(state_q == BC_RESP) & mis_eff, state_q == BC_RESP};

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    logic [CNT_W-1:0] q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) q <= '0;
      else if (clr_stats) q <= '0;
      else if (cnt_inc[g] && q != '1) q <= q + CNT_W'(1);
    end
  end

  assign br_total   = g_cnt[0].q;
  assign br_mispred = g_cnt[1].q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: expected results queued
// on issue, compared when resp_valid pulses.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  localparam int DW = 64;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  cf_kind_e      req_kind;
  cmp_op_enum    req_cmp_op;
  logic [DW-1:0] req_pc, req_rs1, req_rs2, req_imm;
  logic          req_pred_taken;
  logic          resp_valid, resp_taken;
  logic [DW-1:0] link_data, redirect_pc;
  logic          redirect_valid, flush, misalign_exc;
  logic          clr_stats;
  logic [CW-1:0] br_total, br_mispred;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          taken;
    logic [DW-1:0] link;
    logic          redir;
    logic [DW-1:0] rpc;
    logic          misal;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .DATA_W(DW), .FLUSH_CYCLES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_cmp_op(req_cmp_op),
    .req_pc(req_pc), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm),
    .req_pred_taken(req_pred_taken),
    .resp_valid(resp_valid), .resp_taken(resp_taken),
    .link_data(link_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush), .misalign_exc(misalign_exc),
    .clr_stats(clr_stats),
    .br_total(br_total), .br_mispred(br_mispred)
  );

  task automatic check_eq(input string tag,
                          input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input cf_kind_e k, input cmp_op_enum op,
                                 input logic [DW-1:0] pc, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [DW-1:0] imm,
                                 input logic pred);
    exp_t e;
    logic c;
    logic [DW-1:0] tgt;
    case (op)
      CMP_EQ:  c = (a == b);
      CMP_NE:  c = (a != b);
      CMP_LT:  c = ($signed(a) < $signed(b));
      CMP_GE:  c = ($signed(a) >= $signed(b));
      CMP_LTU: c = (a < b);
      default: c = (a >= b);
    endcase
    e.taken = (k == CF_BRANCH) ? c : 1'b1;
    tgt     = (k == CF_JALR) ? ((a + imm) & ~64'h1) : (pc + imm);
    e.link  = pc + 64'd4;
    e.misal = e.taken & tgt[1];
    e.redir = !e.misal && (e.taken != pred);
    e.rpc   = e.taken ? tgt : pc + 64'd4;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rstn && resp_valid) begin
      check_eq("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("resp_taken", 64'(resp_taken), 64'(e.taken));
        check_eq("link_data", link_data, e.link);
        check_eq("redirect_valid", 64'(redirect_valid), 64'(e.redir));
        check_eq("misalign_exc", 64'(misalign_exc), 64'(e.misal));
        check_eq("flush_at_resp", 64'(flush), 64'(e.redir));
        if (e.redir) check_eq("redirect_pc", redirect_pc, e.rpc);
      end
    end else if (rstn) begin
      check_eq("orphan_pulse", {62'd0, redirect_valid, misalign_exc}, 64'd0);
    end
  end

  task automatic send(input cf_kind_e k, input cmp_op_enum op,
                      input logic [DW-1:0] pc, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] imm,
                      input logic pred);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check_eq("ready_timeout", 64'(req_ready), 64'd1);
    req_valid      = 1'b1;
    req_kind       = k;
    req_cmp_op     = op;
    req_pc         = pc;
    req_rs1        = a;
    req_rs2        = b;
    req_imm        = imm;
    req_pred_taken = pred;
    sb.push_back(model(k, op, pc, a, b, imm, pred));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int fl, output int rdy);
    lat = 0;
    fl  = 0;
    rdy = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (resp_valid && lat == 0) lat = i;
      if (flush) fl++;
      if (req_ready) begin
        rdy = i;
        break;
      end
    end
  endtask

  task automatic run_op(input cf_kind_e k, input cmp_op_enum op,
                        input logic [DW-1:0] pc, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] imm,
                        input logic pred,
                        output int lat, output int fl, output int rdy);
    send(k, op, pc, a, b, imm, pred);
    wait_done(lat, fl, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, fl, rdy;
    rstn = 1'b0; req_valid = 1'b0; clr_stats = 1'b0;
    req_kind = CF_BRANCH; req_cmp_op = CMP_EQ; req_pred_taken = 1'b0;
    req_pc = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp", 64'(resp_valid), 64'd0);
    check_eq("rst_taken", 64'(resp_taken), 64'd0);
    check_eq("rst_link", link_data, 64'd0);
    check_eq("rst_redir", 64'(redirect_valid), 64'd0);
    check_eq("rst_rpc", redirect_pc, 64'd0);
    check_eq("rst_flush", 64'(flush), 64'd0);
    check_eq("rst_misal", 64'(misalign_exc), 64'd0);
    check_eq("rst_total", 64'(br_total), 64'd0);
    check_eq("rst_mispred", 64'(br_mispred), 64'd0);
    rstn = 1'b1;

    // BEQ taken, predicted not-taken
    run_op(CF_BRANCH, CMP_EQ, 64'h100, 64'd5, 64'd5, 64'h20, 1'b0, lat, fl, rdy);
    check_eq("t1_lat", 64'(lat), 64'd2);
    check_eq("t1_flush_len", 64'(fl), 64'd2);
    check_eq("t1_ready_cyc", 64'(rdy), 64'd4);

    @(posedge clk); #1 clr_stats = 1'b1;
    @(posedge clk); #1 clr_stats = 1'b0;
    check_eq("clr_total", 64'(br_total), 64'd0);

    // BLT signed: -1 < 1, correctly predicted
    run_op(CF_BRANCH, CMP_LT, 64'h400, '1, 64'd1, 64'h10, 1'b1, lat, fl, rdy);
    check_eq("t2_flush_len", 64'(fl), 64'd0);
    check_eq("t2_ready_cyc", 64'(rdy), 64'd3);
    check_eq("t2_total", 64'(br_total), 64'd1);
    check_eq("t2_mispred", 64'(br_mispred), 64'd0);

    // JALR with bit0 cleared
    run_op(CF_JALR, CMP_EQ, 64'h200, 64'h1001, 64'd0, 64'h4, 1'b0, lat, fl, rdy);
    check_eq("t3_flush_len", 64'(fl), 64'd2);
    check_eq("t3_mispred", 64'(br_mispred), 64'd1);

    // JAL to misaligned target
    run_op(CF_JAL, CMP_EQ, 64'h300, 64'd0, 64'd0, 64'h2, 1'b0, lat, fl, rdy);
    check_eq("t4_lat", 64'(lat), 64'd2);
    check_eq("t4_flush_len", 64'(fl), 64'd0);
    check_eq("t4_ready_cyc", 64'(rdy), 64'd3);
    check_eq("t4_total", 64'(br_total), 64'd3);
    check_eq("t4_mispred", 64'(br_mispred), 64'd1);

    // BNE not taken, predicted taken: redirect to pc+4
    run_op(CF_BRANCH, CMP_NE, 64'h500, 64'd7, 64'd7, 64'h80, 1'b1, lat, fl, rdy);
    check_eq("t4b_flush_len", 64'(fl), 64'd2);
    check_eq("t4b_mispred", 64'(br_mispred), 64'd2);

    // Reset in the middle of the flush window
    send(CF_BRANCH, CMP_NE, 64'h600, 64'd1, 64'd2, 64'h40, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("t5_in_flush", 64'(flush), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check_eq("t5_flush", 64'(flush), 64'd0);
    check_eq("t5_ready", 64'(req_ready), 64'd0);
    check_eq("t5_total", 64'(br_total), 64'd0);
    check_eq("t5_mispred", 64'(br_mispred), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t5_post_flush", 64'(flush), 64'd0);
      check_eq("t5_post_ready", 64'(req_ready), 64'd1);
    end

    // Saturation of both counters
    for (int i = 0; i < 6; i++)
      run_op(CF_BRANCH, CMP_EQ, 64'h100, 64'd5, 64'd5, 64'h20, 1'b0, lat, fl, rdy);
    check_eq("t6_total_pre", 64'(br_total), 64'd6);
    check_eq("t6_mis_pre", 64'(br_mispred), 64'd6);
    for (int i = 0; i < 2; i++) begin
      run_op(CF_BRANCH, CMP_GEU, 64'h700, 64'd9, 64'd3, 64'h8, 1'b0, lat, fl, rdy);
      check_eq("t6_total_sat", 64'(br_total), 64'd7);
      check_eq("t6_mis_sat", 64'(br_mispred), 64'd7);
    end

    // Clear coincident with an increment
    send(CF_BRANCH, CMP_EQ, 64'h100, 64'd5, 64'd5, 64'h20, 1'b1);
    @(posedge clk); #1 clr_stats = 1'b1;
    @(posedge clk); #1 clr_stats = 1'b0;
    check_eq("t6_clr_total", 64'(br_total), 64'd0);
    check_eq("t6_clr_mis", 64'(br_mispred), 64'd0);
    check_eq("t6_clr_ready", 64'(req_ready), 64'd1);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
